// File: rtl/tt_sweep_capture.sv
// Sweeps all 128 input vectors of a 7-input function, captures its output into a
// truth-table signature, counts the ones and compares against a golden signature.
module tt_sweep_capture #(
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] expected,
    output logic [6:0]   x_out,
    output logic         x_vld,
    input  logic         f_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic         tt_valid,
    output logic [7:0]   ones,
    output logic         match
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t     state;
    logic       cap_vld;
    logic [6:0] cap_idx;
    logic       flush;

    assign flush = abort && (state == SWEEP || state == DRAIN);

    // Capture point: the vector index travels alongside the function's own latency.
    if (LAT == 0) begin : g_direct
        assign cap_vld = x_vld;
        assign cap_idx = x_out;
    end else begin : g_delay
        logic [LAT-1:0] dly_vld;
        logic [6:0]     dly_idx [LAT];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: the index chain is tiny, so it is reset along with the valid bits
                // rather than left uninitialised like a real memory would be.
                dly_vld <= '0;
                for (int i = 0; i < LAT; i++) dly_idx[i] <= '0;
            end else if (flush) begin
                dly_vld <= '0;
            end else begin
                dly_vld[0] <= x_vld;
                dly_idx[0] <= x_out;
                for (int i = 1; i < LAT; i++) begin
                    dly_vld[i] <= dly_vld[i-1];
                    dly_idx[i] <= dly_idx[i-1];
                end
            end
        end

        assign cap_vld = dly_vld[LAT-1];
        assign cap_idx = dly_idx[LAT-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_out    <= '0;
            x_vld    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tt       <= '0;
            tt_valid <= 1'b0;
            ones     <= '0;
        end else begin
            // NOTE: done defaults low every edge so it can only ever be a one-cycle pulse;
            // later assignments in this block override earlier ones.
            done <= 1'b0;

            if (cap_vld && !flush) begin
                tt[cap_idx] <= f_in;
                ones        <= ones + {7'd0, f_in};
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= SWEEP;
                        x_out    <= '0;
                        x_vld    <= 1'b1;
                        busy     <= 1'b1;
                        tt       <= '0;
                        ones     <= '0;
                        tt_valid <= 1'b0;
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state <= IDLE;
                        x_vld <= 1'b0;
                        busy  <= 1'b0;
                    end else if (x_out == 7'd127) begin
                        x_vld <= 1'b0;
                        if (LAT == 0) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tt_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        x_out <= x_out + 7'd1;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cap_vld && cap_idx == 7'd127) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        tt_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign match = tt_valid && (tt == expected);

endmodule
